md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the E stage of the five-stage pipeline.
- Successor to the single-cycle ALU path. It adds multi-cycle mult/div with configurable latency, a busy/done handshake, mthi/mtlo writes and a kill input.
- The hazard unit stalls D when an md-class instruction meets `start || busy`.
- W-stage writeback reads HI/LO combinationally through `hi` and `lo`.

---
 rtl/md_unit.sv | 186 ++++++++++++++++++
 tb/tb_md_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
//
// A mult/div op is accepted from IDLE, its operands are latched, and the unit
// stays busy for a fixed number of cycles before writing HI/LO. The result is
// computed combinationally from the latched operands; the down-counter only
// sets the latency. MTHI/MTLO write HI/LO directly at the accepting edge.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   op request, sampled at the rising edge
//   op     in   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   src_a  in   rs operand (dividend / multiplicand / mt data)
//   src_b  in   rt operand (divisor / multiplier)
//   kill   in   synchronous abort; also suppresses a same-cycle start
//   busy   out  high while a mult/div op is in flight
//   done   out  one-cycle pulse after HI/LO take a mult/div result
//   hi     out  HI register
//   lo     out  LO register
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]  r_a, w_a_d;
  logic [WIDTH-1:0]  r_b, w_b_d;
  logic [2:0]        r_op, w_op_d;
  logic [WIDTH-1:0]  r_hi, w_hi_d;
  logic [WIDTH-1:0]  r_lo, w_lo_d;
  logic              r_done, w_done_d;

  // Arithmetic on the latched operands
  logic [2*WIDTH-1:0] w_a_sext, w_b_sext, w_a_zext, w_b_zext;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_b_nz;
  logic [WIDTH-1:0]   w_quot_u, w_rem_u;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot_mag, w_rem_mag;
  logic [WIDTH-1:0]   w_quot_s, w_rem_s;

  assign w_a_sext = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_sext = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_a_zext = {{WIDTH{1'b0}}, r_a};
  assign w_b_zext = {{WIDTH{1'b0}}, r_b};
  // Low 2*WIDTH bits of the product of sign-extended operands is the signed product
  assign w_prod_s = w_a_sext * w_b_sext;
  assign w_prod_u = w_a_zext * w_b_zext;

  // Divisor forced non-zero so the dividers never see 0; the result is discarded then
  assign w_b_zero = (r_b == '0);
  assign w_b_nz   = w_b_zero ? WIDTH'(1) : r_b;
  assign w_quot_u = r_a / w_b_nz;
  assign w_rem_u  = r_a % w_b_nz;

  // Signed divide via magnitudes; most-negative / -1 wraps to most-negative with rem 0
  assign w_abs_a    = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_abs_b    = w_b_nz[WIDTH-1] ? -w_b_nz : w_b_nz;
  assign w_quot_mag = w_abs_a / w_abs_b;
  assign w_rem_mag  = w_abs_a % w_abs_b;
  assign w_quot_s   = (r_a[WIDTH-1] ^ w_b_nz[WIDTH-1]) ? -w_quot_mag : w_quot_mag;
  assign w_rem_s    = r_a[WIDTH-1] ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_op    <= w_op_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_op_d    = r_op;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_done_d  = 1'b0;

    if (kill) begin
      // Kill aborts any in-flight op and masks a same-cycle start
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu: begin
                w_a_d     = src_a;
                w_b_d     = src_b;
                w_op_d    = op;
                w_cnt_d   = CntW'(MULT_CYCLES);
                w_state_d = StRun;
              end
              OpDiv, OpDivu: begin
                w_a_d     = src_a;
                w_b_d     = src_b;
                w_op_d    = op;
                w_cnt_d   = CntW'(DIV_CYCLES);
                w_state_d = StRun;
              end
              OpMthi:  w_hi_d = src_a;
              OpMtlo:  w_lo_d = src_a;
              default: ;
            endcase
          end
        end
        StRun: begin
          // Loaded with N at accept, so the N-th RUN edge is the one reaching 0
          w_cnt_d = r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
            case (r_op)
              OpMult:  {w_hi_d, w_lo_d} = w_prod_s;
              OpMultu: {w_hi_d, w_lo_d} = w_prod_u;
              OpDiv: begin
                if (!w_b_zero) begin
                  w_hi_d = w_rem_s;
                  w_lo_d = w_quot_s;
                end
              end
              OpDivu: begin
                if (!w_b_zero) begin
                  w_hi_d = w_rem_u;
                  w_lo_d = w_quot_u;
                end
              end
              default: ;
            endcase
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign busy = (r_state == StRun);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .src_a(src_a),
    .src_b(src_b),
    .kill (kill),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge, then scramble the operands to prove they were latched
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = 3'd0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Count busy cycles, bounded so a stuck busy cannot hang the run
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_early got %b want 0", done); end
    wait_idle(n);
    n_vec++; if (n != 5) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done got %b want 1", done); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multu();
    int n;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    n_vec++; if (n != 5) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    n_vec++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_vec++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
    tick();
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_vec++; if (n != 10) begin n_err++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL div_done got %b want 1", done); end
    n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
    tick();
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    n_vec++; if (n != 10) begin n_err++; $display("FAIL divz_busy_cycles got %0d want 10", n); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL divz_done got %b want 1", done); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_hi got %h want ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL divz_lo got %h want fffffffd", lo); end
    tick();
  endtask

  task automatic test_div_ovf();
    int n;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_vec++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h want 00000000", hi); end
    tick();
  endtask

  task automatic test_divu();
    int n;
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h want 00000002", hi); end
    tick();
  endtask

  task automatic test_mt();
    issue(3'd5, 32'h1234_5678, 32'h0);
    n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mthi_done got %b want 0", done); end
    issue(3'd6, 32'hCAFE_BABE, 32'h0);
    n_vec++; if (lo !== 32'hCAFE_BABE) begin n_err++; $display("FAIL mtlo_lo got %h want cafebabe", lo); end
    n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_hi got %h want 12345678", hi); end
  endtask

  task automatic test_mt_while_busy();
    int n;
    issue(3'd3, 32'd20, 32'd3);
    tick();
    issue(3'd6, 32'h0000_DEAD, 32'h0);
    n_vec++; if (lo !== 32'hCAFE_BABE) begin n_err++; $display("FAIL mtbusy_lo got %h want cafebabe", lo); end
    issue(3'd5, 32'h0000_BEEF, 32'h0);
    n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mtbusy_hi got %h want 12345678", hi); end
    wait_idle(n);
    n_vec++; if (n != 7) begin n_err++; $display("FAIL mtbusy_remaining got %0d want 7", n); end
    n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL mtbusy_div_lo got %h want 00000006", lo); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL mtbusy_div_hi got %h want 00000002", hi); end
    tick();
  endtask

  task automatic test_kill();
    issue(3'd1, 32'd3, 32'd4);
    tick();
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL kill_busy_c3 got %b want 1", busy); end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL kill_done got %b want 0", done); end
    tick();
    tick();
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL kill_done_late got %b want 0", done); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL kill_hi got %h want 00000002", hi); end
    n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL kill_lo got %h want 00000006", lo); end
  endtask

  task automatic test_kill_start_idle();
    kill = 1'b1;
    issue(3'd5, 32'h0000_0055, 32'h0);
    kill = 1'b0;
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL killstart_hi got %h want 00000002", hi); end
    kill = 1'b1;
    issue(3'd2, 32'd9, 32'd9);
    kill = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL killstart_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd2, 32'd2, 32'd3);
    wait_idle(n);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1 got %b want 1", done); end
    n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL b2b_lo1 got %h want 00000006", lo); end
    issue(3'd2, 32'd4, 32'd5);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got %b want 1", busy); end
    wait_idle(n);
    n_vec++; if (n != 5) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 5", n); end
    n_vec++; if (lo !== 32'd20) begin n_err++; $display("FAIL b2b_lo2 got %h want 00000014", lo); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_hi2 got %h want 00000000", hi); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(3'd3, 32'd50, 32'd5);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got %h want 0", lo); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after_busy got %b want 0", busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    src_a = 32'h0;
    src_b = 32'h0;
    kill  = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_div_ovf();
    test_divu();
    test_mt();
    test_mt_while_busy();
    test_kill();
    test_kill_start_idle();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
